// File: rtl/fm_pkg.sv
// rtl/fm_pkg.sv - shared widths, types and quarter-wave sine table builder for the FM modulator
package fm_pkg;
  localparam int PHASE_W    = 16;
  localparam int SAMPLE_W   = 16;
  localparam int LUT_ADDR_W = 8;
  localparam int LUT_DEPTH  = 1 << LUT_ADDR_W;

  localparam logic [SAMPLE_W-1:0] MAG_DEFAULT = 16'h7FFF;
  localparam logic [SAMPLE_W-1:0] AMPL        = 16'd32767;

  typedef logic [PHASE_W-1:0]         phase_t;
  typedef logic signed [SAMPLE_W-1:0] sample_t;

  // Entry k = round(32767*sin(k*pi/512)); Q30 Taylor series evaluated at elaboration
  function automatic logic [LUT_DEPTH*SAMPLE_W-1:0] build_sin_rom();
    logic [LUT_DEPTH*SAMPLE_W-1:0] rom;
    longint x, x2, term, acc;
    rom = '0;
    for (int k = 0; k < LUT_DEPTH; k++) begin
      x    = (longint'(k) * 64'sd1686629713) >>> LUT_ADDR_W;
      x2   = (x * x) >>> 30;
      term = x;
      acc  = x;
      for (int n = 1; n <= 6; n++) begin
        term = -((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1));
        acc  = acc + term;
      end
      rom[k*SAMPLE_W +: SAMPLE_W] = SAMPLE_W'((acc * 32767 + (64'sd1 <<< 29)) >>> 30);
    end
    return rom;
  endfunction
endpackage

// File: rtl/fm_sincos_lut.sv
// rtl/fm_sincos_lut.sv - quarter-wave sine/cosine lookup with quadrant folding, 2-cycle latency
module fm_sincos_lut
  import fm_pkg::*;
(
  input  logic    clk_i,
  input  logic    rst_i,
  input  logic    ce_i,
  input  phase_t  phase_i,
  output sample_t sin_o,
  output sample_t cos_o
);
  localparam logic [LUT_DEPTH*SAMPLE_W-1:0] SIN_ROM = build_sin_rom();

  logic [1:0]            quad;
  logic [LUT_ADDR_W-1:0] idx;
  logic [LUT_ADDR_W:0]   idx_fwd, idx_rev;
  logic [SAMPLE_W-1:0]   mag_fwd, mag_rev;
  logic [SAMPLE_W-1:0]   sin_mag_d, sin_mag_q, cos_mag_d, cos_mag_q;
  logic                  sin_neg_d, sin_neg_q, cos_neg_d, cos_neg_q;
  sample_t               sin_d, sin_q, cos_d, cos_q;

  // Index LUT_DEPTH is the quarter-wave peak, one past the table end
  function automatic logic [SAMPLE_W-1:0] qsin(input logic [LUT_ADDR_W:0] j);
    if (j[LUT_ADDR_W]) return AMPL;
    return SIN_ROM[j[LUT_ADDR_W-1:0]*SAMPLE_W +: SAMPLE_W];
  endfunction

  always_comb begin
    quad      = phase_i[PHASE_W-1 -: 2];
    idx       = phase_i[PHASE_W-3 -: LUT_ADDR_W];
    idx_fwd   = {1'b0, idx};
    idx_rev   = (LUT_ADDR_W+1)'(LUT_DEPTH) - idx_fwd;
    mag_fwd   = qsin(idx_fwd);
    mag_rev   = qsin(idx_rev);
    sin_mag_d = quad[0] ? mag_rev : mag_fwd;
    cos_mag_d = quad[0] ? mag_fwd : mag_rev;
    sin_neg_d = quad[1];
    cos_neg_d = quad[1] ^ quad[0];
    sin_d     = sin_neg_q ? -sample_t'(sin_mag_q) : sample_t'(sin_mag_q);
    cos_d     = cos_neg_q ? -sample_t'(cos_mag_q) : sample_t'(cos_mag_q);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sin_mag_q <= '0;
      cos_mag_q <= '0;
      sin_neg_q <= 1'b0;
      cos_neg_q <= 1'b0;
      sin_q     <= '0;
      cos_q     <= '0;
    end else if (ce_i) begin
      sin_mag_q <= sin_mag_d;
      cos_mag_q <= cos_mag_d;
      sin_neg_q <= sin_neg_d;
      cos_neg_q <= cos_neg_d;
      sin_q     <= sin_d;
      cos_q     <= cos_d;
    end
  end

  assign sin_o = sin_q;
  assign cos_o = cos_q;
endmodule

// File: rtl/fm_modulate.sv
// rtl/fm_modulate.sv - FM modulator top: AXI-Stream phase accumulator; FM_MODULATE_IQ_EN selects I/Q output
module fm_modulate
  import fm_pkg::*;
#(
  parameter int                  C_S00_AXIS_TDATA_WIDTH = 32,
  parameter int                  C_M00_AXIS_TDATA_WIDTH = 32,
  parameter int                  DEV_SHIFT              = 0,
  parameter logic [SAMPLE_W-1:0] MAG                    = MAG_DEFAULT
) (
  input  logic                                s00_axis_aclk,
  input  logic                                s00_axis_areset,
  input  logic                                s00_axis_tvalid,
  input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
  input  logic [C_S00_AXIS_TDATA_WIDTH/8-1:0] s00_axis_tstrb,
  input  logic                                s00_axis_tlast,
  output logic                                s00_axis_tready,
  input  logic                                m00_axis_tready,
  output logic                                m00_axis_tvalid,
  output logic                                m00_axis_tlast,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
  output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb
);
  localparam int MW = C_M00_AXIS_TDATA_WIDTH / 8;

  logic          en, accept;
  phase_t        incr, phase_d, phase_q;
  logic          v0_q, last0_q;
  logic [MW-1:0] strb_in, strb0_q;
  logic          unused_tdata;

  assign unused_tdata    = ^s00_axis_tdata[C_S00_AXIS_TDATA_WIDTH-1:PHASE_W];
  assign en              = m00_axis_tready | ~m00_axis_tvalid;
  assign s00_axis_tready = en;
  assign accept          = s00_axis_tvalid & en;
  assign strb_in         = MW'(s00_axis_tstrb);

  // Shift in the phase width so bits pushed past bit 15 are dropped
  always_comb begin
    incr    = phase_t'(s00_axis_tdata[PHASE_W-1:0] << DEV_SHIFT);
    phase_d = phase_q;
    if (accept) phase_d = phase_q + incr;
  end

  always_ff @(posedge s00_axis_aclk) begin
    if (s00_axis_areset) begin
      phase_q <= '0;
      v0_q    <= 1'b0;
      last0_q <= 1'b0;
      strb0_q <= '0;
    end else if (en) begin
      phase_q <= phase_d;
      v0_q    <= accept;
      if (accept) begin
        last0_q <= s00_axis_tlast;
        strb0_q <= strb_in;
      end
    end
  end

`ifdef FM_MODULATE_IQ_EN
  sample_t                           sin_s, cos_s;
  logic                              v1_q, v2_q, last1_q, last2_q;
  logic [MW-1:0]                     strb1_q, strb2_q;
  logic [C_M00_AXIS_TDATA_WIDTH-1:0] data_iq;

  fm_sincos_lut u_lut (
    .clk_i   (s00_axis_aclk),
    .rst_i   (s00_axis_areset),
    .ce_i    (en),
    .phase_i (phase_q),
    .sin_o   (sin_s),
    .cos_o   (cos_s)
  );

  // Sideband shadows the two LUT register stages
  always_ff @(posedge s00_axis_aclk) begin
    if (s00_axis_areset) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      last1_q <= 1'b0;
      last2_q <= 1'b0;
      strb1_q <= '0;
      strb2_q <= '0;
    end else if (en) begin
      v1_q    <= v0_q;
      v2_q    <= v1_q;
      last1_q <= last0_q;
      last2_q <= last1_q;
      strb1_q <= strb0_q;
      strb2_q <= strb1_q;
    end
  end

  always_comb begin
    data_iq                     = '0;
    data_iq[2*SAMPLE_W-1:0]     = {sin_s, cos_s};
  end

  assign m00_axis_tvalid = v2_q;
  assign m00_axis_tlast  = last2_q;
  assign m00_axis_tstrb  = strb2_q;
  assign m00_axis_tdata  = data_iq;
`else
  logic [C_M00_AXIS_TDATA_WIDTH-1:0] data_d, data_q;

  always_comb begin
    data_d                  = '0;
    data_d[2*SAMPLE_W-1:0]  = {phase_d, MAG};
  end

  always_ff @(posedge s00_axis_aclk) begin
    if (s00_axis_areset) data_q <= '0;
    else if (accept)     data_q <= data_d;
  end

  assign m00_axis_tvalid = v0_q;
  assign m00_axis_tlast  = last0_q;
  assign m00_axis_tstrb  = strb0_q;
  assign m00_axis_tdata  = data_q;
`endif
endmodule

// File: tb/tb_fm_modulate.sv
// tb/tb_fm_modulate.sv - self-checking bench for fm_modulate (phase mode, or I/Q with FM_MODULATE_IQ_EN)
`timescale 1ns/1ps
module tb_fm_modulate;
  localparam int          DW    = 32;
  localparam int          SHIFT = 0;
  localparam logic [15:0] MAGV  = 16'h7FFF;
`ifdef FM_MODULATE_IQ_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_tvalid = 1'b0, s_tlast = 1'b0, s_tready;
  logic [DW-1:0] s_tdata = '0;
  logic [3:0]    s_tstrb = '0;
  logic          m_tready = 1'b1, m_tvalid, m_tlast;
  logic [DW-1:0] m_tdata;
  logic [3:0]    m_tstrb;
  int            n_checks = 0, n_pass = 0;

  typedef struct { logic [15:0] word; logic last; logic [3:0] strb; logic [15:0] exp_ph; } vec_t;
  typedef struct { int ph; logic last; logic [3:0] strb; } beat_t;

  vec_t  vecs[15];
  beat_t exp_q[$];
  beat_t sb_b;
  int    model_phase = 0;
  logic  prev_stall = 1'b0;
  logic [36:0] prev_out = '0;

  always #5 clk = ~clk;

  fm_modulate #(
    .C_S00_AXIS_TDATA_WIDTH (DW),
    .C_M00_AXIS_TDATA_WIDTH (DW),
    .DEV_SHIFT              (SHIFT),
    .MAG                    (MAGV)
  ) dut (
    .s00_axis_aclk   (clk),
    .s00_axis_areset (rst),
    .s00_axis_tvalid (s_tvalid),
    .s00_axis_tdata  (s_tdata),
    .s00_axis_tstrb  (s_tstrb),
    .s00_axis_tlast  (s_tlast),
    .s00_axis_tready (s_tready),
    .m00_axis_tready (m_tready),
    .m00_axis_tvalid (m_tvalid),
    .m00_axis_tlast  (m_tlast),
    .m00_axis_tdata  (m_tdata),
    .m00_axis_tstrb  (m_tstrb)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic chk_beat(input string name, input logic [31:0] d, input int ph);
`ifdef FM_MODULATE_IQ_EN
    real th, c, s;
    int  ei, eq, ai, aq;
    th = 2.0 * 3.14159265358979 * real'(ph & 16'hFFC0) / 65536.0;
    c  = $cos(th) * 32767.0;
    s  = $sin(th) * 32767.0;
    ei = $rtoi(c >= 0.0 ? c + 0.5 : c - 0.5);
    eq = $rtoi(s >= 0.0 ? s + 0.5 : s - 0.5);
    ai = int'($signed(d[15:0]));
    aq = int'($signed(d[31:16]));
    n_checks++;
    if (ai - ei <= 1 && ei - ai <= 1 && aq - eq <= 1 && eq - aq <= 1) n_pass++;
    else $display("FAIL %s: got I=%0d Q=%0d expected I=%0d Q=%0d (+-1) phase %h", name, ai, aq, ei, eq, ph);
`else
    chk(name, d, {ph[15:0], MAGV});
`endif
  endtask

  // Scoreboard: every accepted input beat must emerge once, in order, with its sideband
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      model_phase = 0;
      prev_stall  = 1'b0;
    end else begin
      chk("tready_rule", s_tready, m_tready || !m_tvalid);
      if (prev_stall) begin
        chk("stall_tvalid", m_tvalid, 1'b1);
        chk("stall_hold", {m_tdata, m_tlast, m_tstrb}, prev_out);
      end
      if (m_tvalid && m_tready) begin
        chk("beat_expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          sb_b = exp_q.pop_front();
          chk_beat("sb_data", m_tdata, sb_b.ph);
          chk("sb_tlast", m_tlast, sb_b.last);
          chk("sb_tstrb", m_tstrb, sb_b.strb);
        end
      end
      if (s_tvalid && s_tready) begin
        model_phase = (model_phase + (int'(s_tdata[15:0]) << SHIFT)) & 32'hFFFF;
        exp_q.push_back('{model_phase, s_tlast, s_tstrb});
      end
      prev_stall = m_tvalid && !m_tready;
      prev_out   = {m_tdata, m_tlast, m_tstrb};
    end
  end

  task automatic send_check(input vec_t v, input string nm);
    chk({nm, "_idle"}, m_tvalid, 1'b0);
    s_tdata  = {16'hA5A5, v.word};
    s_tlast  = v.last;
    s_tstrb  = v.strb;
    s_tvalid = 1'b1;
    m_tready = 1'b1;
    @(posedge clk); #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tstrb  = 4'h0;
    repeat (LAT - 1) @(posedge clk);
    #1;
    chk({nm, "_tvalid"}, m_tvalid, 1'b1);
    chk_beat({nm, "_data"}, m_tdata, int'(v.exp_ph));
    chk({nm, "_tlast"}, m_tlast, v.last);
    chk({nm, "_tstrb"}, m_tstrb, v.strb);
    @(posedge clk); #1;
  endtask

  // mode 0: 5-cycle backpressure, 1: tlast on beat 3 with alternating strobes, 2: random
  task automatic run_stream(input int nbeats, input int mode);
    int   i = 0;
    int   cyc = 0;
    logic acc, holding = 1'b0;
    while (i < nbeats && cyc < 5000) begin
      if (!holding) begin
        s_tvalid = (mode != 2) || ($urandom_range(3) != 0);
        s_tdata  = {16'h0000, (mode == 1) ? 16'h2000 : 16'($urandom)};
        s_tlast  = (mode == 1) ? (i == 2) : (mode == 2 ? 1'($urandom) : (i == nbeats - 1));
        s_tstrb  = (mode == 1) ? (i[0] ? 4'h3 : 4'hF) : (mode == 2 ? 4'($urandom) : 4'hF);
      end
      if (mode == 0)      m_tready = !(cyc >= 3 && cyc < 8);
      else if (mode == 2) m_tready = ($urandom_range(9) < 7);
      else                m_tready = 1'b1;
      @(negedge clk);
      acc     = s_tvalid && s_tready;
      holding = s_tvalid && !acc;
      @(posedge clk); #1;
      if (acc) i++;
      cyc++;
    end
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    chk("stream_beats_sent", i, nbeats);
  endtask

  task automatic drain();
    int k = 0;
    m_tready = 1'b1;
    s_tvalid = 1'b0;
    while (exp_q.size() != 0 && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    chk("drain_empty", exp_q.size(), 0);
    chk("drain_idle", m_tvalid, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs = '{
      '{16'h1000, 1'b0, 4'hF, 16'h1000},
      '{16'h1000, 1'b0, 4'h3, 16'h2000},
      '{16'h1000, 1'b0, 4'hF, 16'h3000},
      '{16'h1000, 1'b1, 4'h3, 16'h4000},
      '{16'hB000, 1'b0, 4'hF, 16'hF000},
      '{16'h2000, 1'b0, 4'h1, 16'h1000},
      '{16'hF000, 1'b1, 4'hF, 16'h0000},
      '{16'h8000, 1'b0, 4'hC, 16'h8000},
      '{16'h8000, 1'b0, 4'hF, 16'h0000},
      '{16'hFFFF, 1'b0, 4'h3, 16'hFFFF},
      '{16'h0001, 1'b1, 4'hF, 16'h0000},
      '{16'h4000, 1'b0, 4'hF, 16'h4000},
      '{16'h4000, 1'b0, 4'h3, 16'h8000},
      '{16'h4000, 1'b0, 4'hF, 16'hC000},
      '{16'h4000, 1'b1, 4'h3, 16'h0000}
    };

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", m_tvalid, 1'b0);
    chk("rst_tdata", m_tdata, 32'h0);
    chk("rst_tlast", m_tlast, 1'b0);
    chk("rst_tstrb", m_tstrb, 4'h0);
    chk("rst_tready", s_tready, 1'b1);
    rst = 1'b0;

    for (int i = 0; i < 15; i++) send_check(vecs[i], $sformatf("vec%0d", i));

    run_stream(12, 0);
    drain();
    run_stream(4, 1);
    drain();

    m_tready = 1'b0;
    s_tvalid = 1'b1;
    s_tdata  = 32'h0000_1111;
    s_tstrb  = 4'hF;
    @(posedge clk); #1;
    s_tdata  = 32'h0000_2222;
    @(posedge clk); #1;
    s_tvalid = 1'b0;
    rst      = 1'b1;
    @(posedge clk); #1;
    chk("midrst_tvalid", m_tvalid, 1'b0);
    chk("midrst_tdata", m_tdata, 32'h0);
    chk("midrst_tready", s_tready, 1'b1);
    rst      = 1'b0;
    m_tready = 1'b1;
    @(posedge clk); #1;
    chk("postrst_idle", m_tvalid, 1'b0);
    send_check('{16'h0100, 1'b0, 4'hF, 16'h0100}, "postrst");

    run_stream(300, 2);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/fm_modulate.md
FM_MODULATE -- requirements
Module: fm_modulate

Interface
REQ-001 SHALL have parameter C_S00_AXIS_TDATA_WIDTH, default 32, input AXI-Stream data width.
REQ-002 SHALL have parameter C_M00_AXIS_TDATA_WIDTH, default 32, output AXI-Stream data width.
REQ-003 SHALL have parameter DEV_SHIFT, default 0, left-shift (0..8) applied to the input frequency word.
REQ-004 SHALL have parameter MAG, default 16'h7FFF, constant magnitude emitted in phase mode.
REQ-005 s00_axis_aclk  input  1  sole clock; all logic on its rising edge.
REQ-006 s00_axis_areset  input  1  reset, synchronous and active-high.
REQ-007 s00_axis_tvalid  input  1  input beat valid.
REQ-008 s00_axis_tdata  input  C_S00_AXIS_TDATA_WIDTH  [15:0] signed frequency word (phase increment per sample); [31:16] ignored.
REQ-009 s00_axis_tstrb  input  C_S00_AXIS_TDATA_WIDTH/8  byte strobes, passed through.
REQ-010 s00_axis_tlast  input  1  end of packet, passed through.
REQ-011 s00_axis_tready  output  1  input accepted when high with tvalid.
REQ-012 m00_axis_tready  input  1  downstream ready.
REQ-013 m00_axis_tvalid, m00_axis_tlast  output  1 each  output valid / end of packet.
REQ-014 m00_axis_tdata  output  C_M00_AXIS_TDATA_WIDTH  phase mode: [31:16] phase, [15:0] MAG; IQ mode: [31:16] Q (sin), [15:0] I (cos), signed.
REQ-015 m00_axis_tstrb  output  C_M00_AXIS_TDATA_WIDTH/8  delayed copy of s00_axis_tstrb.

Function
REQ-016 Pipeline enable en SHALL equal m00_axis_tready OR NOT m00_axis_tvalid; s00_axis_tready SHALL equal en (combinational).
REQ-017 On accept (tvalid AND tready) the 16-bit phase accumulator SHALL update to phase + (tdata[15:0] <<< DEV_SHIFT), modulo 2^16, two's-complement wrap, shifted-out bits discarded.
REQ-018 The emitted phase SHALL be the post-update value; first beat after reset with word D emits phase D<<<DEV_SHIFT.
REQ-019 Accumulator SHALL NOT change on cycles without accept; phase SHALL be continuous across tlast boundaries.
REQ-020 Phase-mode latency SHALL be 1 cycle from accept to m00_axis_tvalid high.
REQ-021 When en is low all pipeline stages, tdata, tlast, tstrb SHALL hold; m00_axis_tvalid SHALL not drop while m00_axis_tready is low.
REQ-022 When en is high with no accept, a valid bubble SHALL propagate (stage valid bits shift in 0).
REQ-023 tlast and tstrb SHALL travel with their beat through every stage.
REQ-024 Simultaneous output handshake and input accept SHALL produce back-to-back valid beats at 1 beat/cycle.

Reset
REQ-025 On s00_axis_areset high at a clock edge: phase accumulator, all stage valids, m00_axis_tvalid, m00_axis_tdata, m00_axis_tlast, m00_axis_tstrb SHALL become 0.
REQ-026 Reset mid-stream SHALL discard in-flight beats; no partial beat emitted after reset deasserts.
REQ-027 During reset s00_axis_tready SHALL be 1 (m00_axis_tvalid is 0); beats presented then are dropped.

Configuration
REQ-028 Macro FM_MODULATE_IQ_EN defined: phase feeds sub-module fm_sincos_lut; output is {Q,I}; latency 3 cycles; LUT stages stall with en.
REQ-029 Macro FM_MODULATE_IQ_EN undefined: no LUT instantiated; output {phase, MAG}; latency 1 cycle.

Structure
REQ-030 Package fm_pkg SHALL hold PHASE_W=16, SAMPLE_W=16, LUT_ADDR_W=8, MAG default, and typedef phase_t.
REQ-031 Sub-module fm_sincos_lut SHALL implement a 256-entry quarter-wave sine ROM with quadrant folding, 2-cycle registered latency, clock-enable input, amplitude 32767.

Verification
REQ-032 Phase mode, DEV_SHIFT=0, words 0x1000 x4, tready=1 -> phases 0x1000,0x2000,0x3000,0x4000 in [31:16], [15:0]=0x7FFF, 1-cycle latency.
REQ-033 Wrap: accumulator 0xF000, word 0x2000 -> phase 0x1000; word 0x8000 (negative) from 0x0000 -> 0x8000.
REQ-034 Backpressure: hold m00_axis_tready low 5 cycles mid-stream -> s00_axis_tready low, output data/tvalid stable, no beat lost or duplicated, phase sequence unchanged.
REQ-035 tlast on beat 3 of 4 with tstrb 4'hF/4'h3 alternating -> tlast and tstrb appear on exactly matching output beats; phase continues across boundary.
REQ-036 IQ mode: words 0x4000 x4 -> (I,Q) = (0,32767),(-32767,0),(0,-32767),(32767,0) ±1 LSB, 3-cycle latency.
REQ-037 Reset asserted with 2 beats in flight -> next cycle m00_axis_tvalid=0; first beat 0x0100 after release emits phase 0x0100.
